// File: rtl/cc_speed_pkg.sv
// Shared definitions for the speed counter and the downstream comparator:
// level encoding, default data width and the all-ones period endpoint.
package cc_speed_pkg;

   localparam int SPEEDCOUNTER_DATAWIDTH_DEF = 25;

   localparam logic [1:0] LVL0 = 2'd0;
   localparam logic [1:0] LVL1 = 2'd1;
   localparam logic [1:0] LVL2 = 2'd2;
   localparam logic [1:0] LVL3 = 2'd3;

   typedef enum logic [1:0] {
      ST_LVL0 = LVL0,
      ST_LVL1 = LVL1,
      ST_LVL2 = LVL2,
      ST_LVL3 = LVL3
   } lvl_state_e;

   // All-ones value of a w-bit bus; callers slice to their own width.
   function automatic logic [63:0] cc_max(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/cc_speedlevel_fsm.sv
// Four-level speed FSM: each cycle levelup_i is high advances one level,
// saturating at LVL3. Only reset returns it to LVL0.
module cc_speedlevel_fsm
   import cc_speed_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       levelup_i,
   output logic [1:0] level_o
);

   lvl_state_e state_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_LVL0;
      end else if (levelup_i) begin
         case (state_q)
            ST_LVL0: state_q <= ST_LVL1;
            ST_LVL1: state_q <= ST_LVL2;
            ST_LVL2: state_q <= ST_LVL3;
            default: state_q <= ST_LVL3;
         endcase
      end
   end

   assign level_o = state_q;

endmodule

// File: rtl/cc_speedcounter.sv
// Free-running period counter stepping by 1 << level; always lands on all-ones
// for exactly one cycle per period so a downstream all-ones compare fires once.
module cc_speedcounter
   import cc_speed_pkg::*;
#(
   parameter int SPEEDCOUNTER_DATAWIDTH = SPEEDCOUNTER_DATAWIDTH_DEF,
   parameter int SPEEDCOUNTER_LEVELS    = 4
) (
   input  logic                              CC_SPEEDCOUNTER_CLOCK_50,
   input  logic                              CC_SPEEDCOUNTER_RESET_InLow,
   input  logic                              CC_SPEEDCOUNTER_clear_InHigh,
   input  logic                              CC_SPEEDCOUNTER_pause_InHigh,
   input  logic                              CC_SPEEDCOUNTER_levelup_InHigh,
   output logic [SPEEDCOUNTER_DATAWIDTH-1:0] CC_SPEEDCOUNTER_data_OutBUS,
   output logic [1:0]                        CC_SPEEDCOUNTER_level_OutBUS
);

   localparam int DW = SPEEDCOUNTER_DATAWIDTH;
   localparam int LW = $clog2(SPEEDCOUNTER_LEVELS);
   localparam logic [63:0]   MAX64 = cc_max(DW);
   localparam logic [DW-1:0] MAX   = MAX64[DW-1:0];

   logic [LW-1:0] level;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] step, remain;

   cc_speedlevel_fsm u_level (
      .clk_i     (CC_SPEEDCOUNTER_CLOCK_50),
      .rst_ni    (CC_SPEEDCOUNTER_RESET_InLow),
      .levelup_i (CC_SPEEDCOUNTER_levelup_InHigh),
      .level_o   (level)
   );

   // The step uses the level register value, so a levelup sampled this edge
   // only affects the count from the following edge.
   always_comb begin
      step   = {{(DW-1){1'b0}}, 1'b1} << level;
      remain = MAX - cnt_q;
      cnt_d  = cnt_q;
      if (CC_SPEEDCOUNTER_clear_InHigh)      cnt_d = '0;
      else if (CC_SPEEDCOUNTER_pause_InHigh) cnt_d = cnt_q;
      else if (cnt_q == MAX)                 cnt_d = '0;
      else if (remain <= step)               cnt_d = MAX;
      else                                   cnt_d = cnt_q + step;
   end

   always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50) begin
      if (!CC_SPEEDCOUNTER_RESET_InLow) cnt_q <= '0;
      else                              cnt_q <= cnt_d;
   end

   assign CC_SPEEDCOUNTER_data_OutBUS  = cnt_q;
   assign CC_SPEEDCOUNTER_level_OutBUS = level;

endmodule

// File: tb/tb_cc_speedcounter.sv
// Bench for cc_speedcounter at DW=4: directed scenarios against literal
// sequences plus a randomized run against an arithmetic reference model.
module tb_cc_speedcounter;

   localparam int DW   = 4;
   localparam int MAXV = 15;

   logic          clk = 1'b0;
   logic          rst_n, clr, pau, lup;
   logic [DW-1:0] data;
   logic [1:0]    level;

   int errors = 0;
   int checks = 0;
   int m_cnt  = 0;
   int m_lvl  = 0;

   cc_speedcounter #(.SPEEDCOUNTER_DATAWIDTH(DW), .SPEEDCOUNTER_LEVELS(4)) dut (
      .CC_SPEEDCOUNTER_CLOCK_50       (clk),
      .CC_SPEEDCOUNTER_RESET_InLow    (rst_n),
      .CC_SPEEDCOUNTER_clear_InHigh   (clr),
      .CC_SPEEDCOUNTER_pause_InHigh   (pau),
      .CC_SPEEDCOUNTER_levelup_InHigh (lup),
      .CC_SPEEDCOUNTER_data_OutBUS    (data),
      .CC_SPEEDCOUNTER_level_OutBUS   (level)
   );

   always #5 clk = ~clk;

   // One clock edge; the model advances from the inputs held across the edge.
   task automatic tick();
      int st, nc;
      @(posedge clk);
      if (!rst_n) begin
         m_cnt = 0;
         m_lvl = 0;
      end else begin
         st = 1 << m_lvl;
         if (clr)                 nc = 0;
         else if (pau)            nc = m_cnt;
         else if (m_cnt == MAXV)  nc = 0;
         else if (m_cnt + st >= MAXV) nc = MAXV;
         else                     nc = m_cnt + st;
         m_cnt = nc;
         if (lup && m_lvl < 3) m_lvl = m_lvl + 1;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; clr = 1'b0; pau = 1'b0; lup = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b1; pau = 1'b1; lup = 1'b1;
      tick(); tick();
      checks++;
      if (data !== 4'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", data); end
      checks++;
      if (level !== 2'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
      rst_n = 1'b1; clr = 1'b0; pau = 1'b0; lup = 1'b0;
   endtask

   task automatic test_lvl0_period();
      int hits = 0;
      do_reset();
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (data == 4'(MAXV)) hits++;
         checks++;
         if (data !== 4'(k % 16)) begin
            errors++; $display("FAIL lvl0_seq k=%0d got=%0d exp=%0d", k, data, k % 16);
         end
      end
      checks++;
      if (hits != 2) begin errors++; $display("FAIL lvl0_max_hits got=%0d exp=2", hits); end
      checks++;
      if (level !== 2'd0) begin errors++; $display("FAIL lvl0_level got=%0d exp=0", level); end
   endtask

   task automatic test_levelup_seq();
      int exp1 [9] = '{1, 3, 5, 7, 9, 11, 13, 15, 0};
      int exp3 [5] = '{8, 15, 0, 8, 15};
      do_reset();
      lup = 1'b1;
      for (int k = 0; k < 9; k++) begin
         tick();
         lup = 1'b0;
         checks++;
         if (data !== 4'(exp1[k])) begin
            errors++; $display("FAIL lvl1_seq k=%0d got=%0d exp=%0d", k, data, exp1[k]);
         end
      end
      checks++;
      if (level !== 2'd1) begin errors++; $display("FAIL lvl1_level got=%0d exp=1", level); end
      pau = 1'b1; lup = 1'b1;
      tick(); tick();
      pau = 1'b0; lup = 1'b0;
      checks++;
      if (data !== 4'd0 || level !== 2'd3) begin
         errors++; $display("FAIL lvl3_setup got=%0d/%0d exp=0/3", data, level);
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (data !== 4'(exp3[k])) begin
            errors++; $display("FAIL lvl3_seq k=%0d got=%0d exp=%0d", k, data, exp3[k]);
         end
      end
   endtask

   task automatic test_level_sat();
      int expl [5] = '{1, 2, 3, 3, 3};
      do_reset();
      pau = 1'b1; lup = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (level !== 2'(expl[k])) begin
            errors++; $display("FAIL level_sat k=%0d got=%0d exp=%0d", k, level, expl[k]);
         end
      end
      pau = 1'b0; lup = 1'b0;
      tick(); tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if (data !== 4'd0 || level !== 2'd3) begin
         errors++; $display("FAIL clear_keeps_level got=%0d/%0d exp=0/3", data, level);
      end
   endtask

   task automatic test_clear_pause();
      do_reset();
      repeat (6) tick();
      pau = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (data !== 4'd6) begin errors++; $display("FAIL pause_hold got=%0d exp=6", data); end
      end
      clr = 1'b1;
      tick();
      checks++;
      if (data !== 4'd0) begin errors++; $display("FAIL clear_over_pause got=%0d exp=0", data); end
      clr = 1'b0; pau = 1'b0;
      tick();
      checks++;
      if (data !== 4'd1) begin errors++; $display("FAIL resume1 got=%0d exp=1", data); end
      tick();
      checks++;
      if (data !== 4'd2) begin errors++; $display("FAIL resume2 got=%0d exp=2", data); end
      repeat (13) tick();
      pau = 1'b1;
      repeat (3) tick();
      checks++;
      if (data !== 4'd15) begin errors++; $display("FAIL pause_at_max got=%0d exp=15", data); end
      pau = 1'b0;
      tick();
      checks++;
      if (data !== 4'd0) begin errors++; $display("FAIL wrap_after_pause got=%0d exp=0", data); end
   endtask

   task automatic test_simul();
      do_reset();
      repeat (14) tick();
      lup = 1'b1;
      tick();
      lup = 1'b0;
      checks++;
      if (data !== 4'd15 || level !== 2'd1) begin
         errors++; $display("FAIL simul_old_step got=%0d/%0d exp=15/1", data, level);
      end
      tick();
      checks++;
      if (data !== 4'd0) begin errors++; $display("FAIL simul_wrap got=%0d exp=0", data); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pau = 1'b1; lup = 1'b1;
      tick(); tick();
      pau = 1'b0; lup = 1'b0;
      repeat (3) tick();
      checks++;
      if (data !== 4'd12 || level !== 2'd2) begin
         errors++; $display("FAIL mid_setup got=%0d/%0d exp=12/2", data, level);
      end
      rst_n = 1'b0; lup = 1'b1;
      tick();
      rst_n = 1'b1; lup = 1'b0;
      checks++;
      if (data !== 4'd0 || level !== 2'd0) begin
         errors++; $display("FAIL mid_reset got=%0d/%0d exp=0/0", data, level);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 2000; k++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         clr   = ($urandom_range(0, 19) == 0);
         pau   = ($urandom_range(0, 6) == 0);
         lup   = ($urandom_range(0, 24) == 0);
         tick();
         checks++;
         if (data !== 4'(m_cnt) || level !== 2'(m_lvl)) begin
            errors++;
            $display("FAIL random k=%0d got=%0d/%0d exp=%0d/%0d", k, data, level, m_cnt, m_lvl);
         end
      end
      rst_n = 1'b1; clr = 1'b0; pau = 1'b0; lup = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; pau = 1'b0; lup = 1'b0;
      test_reset();
      test_lvl0_period();
      test_levelup_seq();
      test_level_sat();
      test_clear_pause();
      test_simul();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
